// File: rtl/fc_feature_tx_if.sv
// Valid/ready bundle for fc_feature_tx: feature-word write port from the flatten/pool
// stage plus the valid/ready/last stream to the dense-layer input.
interface fc_feature_tx_if #(
   parameter int DATA_W = 16,
   parameter int IDX_W  = 7
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [IDX_W-1:0]  out_index;
   logic              out_last;
   logic              frame_done;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_index, out_last, frame_done
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data, out_index, out_last, frame_done
   );
endinterface

// File: rtl/fc_feature_tx.sv
// Frame buffer feeding the FC classifier: captures NUM_FEAT words, then streams them out.
// Define FC_TX_PINGPONG_EN for two banks so capture of the next frame overlaps transmission.
module fc_feature_tx #(
   parameter int DATA_W   = 16,
   parameter int NUM_FEAT = 120,
   parameter int IDX_W    = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   fc_feature_tx_if.slave bus
);

`ifdef FC_TX_PINGPONG_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif
   localparam int                ADDR_W     = $clog2(NUM_BANKS * NUM_FEAT);
   localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_FEAT - 1);
   localparam logic [ADDR_W-1:0] BANK1_BASE = ADDR_W'(NUM_FEAT);

   typedef enum logic {IDLE, SEND} state_t;

   logic [DATA_W-1:0] mem [NUM_BANKS*NUM_FEAT];
   logic [IDX_W-1:0]  wr_ptr;
   logic [IDX_W-1:0]  rd_ptr;
   logic [IDX_W-1:0]  rd_idx;
   logic              wr_bank;
   logic              rd_bank;
   logic [1:0]        full;
   logic [1:0]        full_nxt;
   logic [ADDR_W-1:0] wr_addr;
   logic [ADDR_W-1:0] rd_addr;
   logic              in_ready_w;
   logic              in_fire;
   logic              out_fire;
   logic              wr_wrap;
   logic              rd_wrap;
   state_t            state;
   logic              out_valid_q;
   logic              out_last_q;
   logic              frame_done_q;
   logic [DATA_W-1:0] out_data_q;

   assign in_ready_w = !full[wr_bank];
   assign in_fire    = bus.in_valid & in_ready_w;
   assign out_fire   = (state == SEND) & out_valid_q & bus.out_ready;
   assign wr_wrap    = in_fire & (wr_ptr == LAST_IDX);
   assign rd_wrap    = out_fire & (rd_ptr == LAST_IDX);

   // The read address looks one word ahead so the next word is ready at the handshake edge.
   assign rd_idx  = (state == IDLE) ? '0 : rd_ptr + 1'b1;
   assign wr_addr = (wr_bank ? BANK1_BASE : '0) + ADDR_W'(wr_ptr);
   assign rd_addr = (rd_bank ? BANK1_BASE : '0) + ADDR_W'(rd_idx);

   assign bus.in_ready   = in_ready_w;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_data   = out_data_q;
   assign bus.out_index  = rd_ptr;
   assign bus.out_last   = out_last_q;
   assign bus.frame_done = frame_done_q;

`ifdef FC_TX_PINGPONG_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
      end else begin
         if (wr_wrap) wr_bank <= ~wr_bank;
         if (rd_wrap) rd_bank <= ~rd_bank;
      end
   end
`else
   assign wr_bank = 1'b0;
   assign rd_bank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (in_fire) mem[wr_addr] <= bus.in_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
      end else if (in_fire) begin
         wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
      end
   end

   // Set and clear always target different banks, so both may apply in one cycle.
   always_comb begin
      full_nxt = full;
      if (rd_wrap) full_nxt[rd_bank] = 1'b0;
      if (wr_wrap) full_nxt[wr_bank] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) full <= '0;
      else        full <= full_nxt;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         rd_ptr       <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         out_last_q   <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (full[rd_bank]) begin
                  out_data_q  <= mem[rd_addr];
                  rd_ptr      <= '0;
                  out_valid_q <= 1'b1;
                  out_last_q  <= (LAST_IDX == '0);
                  state       <= SEND;
               end
            end
            SEND: begin
               if (out_fire) begin
                  if (rd_ptr == LAST_IDX) begin
                     out_valid_q  <= 1'b0;
                     out_last_q   <= 1'b0;
                     frame_done_q <= 1'b1;
                     state        <= IDLE;
                  end else begin
                     rd_ptr     <= rd_idx;
                     out_data_q <= mem[rd_addr];
                     out_last_q <= (rd_idx == LAST_IDX);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fc_feature_tx.sv
// Self-checking bench for fc_feature_tx: random traffic against a queue-based frame model.
// Build with or without FC_TX_PINGPONG_EN to match the design configuration.
module tb_fc_feature_tx;
   localparam int DATA_W   = 16;
   localparam int NUM_FEAT = 120;
   localparam int IDX_W    = 7;
`ifdef FC_TX_PINGPONG_EN
   localparam int NUM_BANKS = 2;
`else
   localparam int NUM_BANKS = 1;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   fc_feature_tx_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

   fc_feature_tx #(.DATA_W(DATA_W), .NUM_FEAT(NUM_FEAT), .IDX_W(IDX_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int ready_mode = 1;

   logic [DATA_W-1:0] wq[$];
   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] obs_data[$];
   logic [IDX_W-1:0]  obs_idx[$];
   logic              obs_last[$];
   int                rise_cycles[$];
   int                last_cycles[$];
   int valid_cycles, done_count, stab_err, stall_cycles, last_err;
   logic              prev_valid = 1'b0;
   logic              prev_ready = 1'b0;
   logic [DATA_W-1:0] prev_data  = '0;
   logic [IDX_W-1:0]  prev_idx   = '0;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       bus.out_ready = 1'b0;
            1:       bus.out_ready = 1'b1;
            2:       bus.out_ready = !bus.out_ready;
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Passive observer: records every output handshake and protocol irregularities.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.out_valid && bus.out_ready) begin
            obs_data.push_back(bus.out_data);
            obs_idx.push_back(bus.out_index);
            obs_last.push_back(bus.out_last);
            if (bus.out_last) last_cycles.push_back(cyc);
         end
         if (bus.out_valid) valid_cycles++;
         if (bus.out_valid && !prev_valid) rise_cycles.push_back(cyc);
         if (bus.frame_done) done_count++;
         if (rst_n && prev_valid && !prev_ready &&
             (!bus.out_valid || bus.out_data !== prev_data || bus.out_index !== prev_idx))
            stab_err++;
         if (bus.in_valid && !bus.in_ready) stall_cycles++;
         if (bus.out_last !== (bus.out_valid && bus.out_index == IDX_W'(NUM_FEAT - 1))) last_err++;
         prev_valid = bus.out_valid;
         prev_ready = bus.out_ready;
         prev_data  = bus.out_data;
         prev_idx   = bus.out_index;
      end
   end

   task automatic clear_obs();
      obs_data.delete();
      obs_idx.delete();
      obs_last.delete();
      rise_cycles.delete();
      last_cycles.delete();
      exp_q.delete();
      valid_cycles = 0;
      done_count   = 0;
      stab_err     = 0;
      stall_cycles = 0;
      last_err     = 0;
   endtask

   // Offers wq word by word; every accepted word joins the expected output stream.
   task automatic send_words(input int max_cycles, input int gap_pct,
                             output int accepted, output int last_acc);
      int idx = 0;
      int n   = 0;
      last_acc = -1;
      while (idx < wq.size() && n < max_cycles) begin
         bus.in_valid = ($urandom_range(0, 99) >= gap_pct);
         bus.in_data  = wq[idx];
         @(negedge clk);
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(wq[idx]);
            idx++;
            last_acc = cyc;
         end
         @(posedge clk);
         #1;
         n++;
      end
      bus.in_valid = 1'b0;
      accepted = idx;
   endtask

   task automatic wait_drain();
      int n = 0;
      while (obs_data.size() < exp_q.size() && n < 3000) begin
         @(posedge clk);
         #1;
         n++;
      end
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected index and last flag follow from the word's position in the stream.
   function automatic int stream_errors();
      int errs = 0;
      for (int k = 0; k < obs_data.size() && k < exp_q.size(); k++) begin
         if (obs_data[k] !== exp_q[k]) errs++;
         if (obs_idx[k] !== IDX_W'(k % NUM_FEAT)) errs++;
         if (obs_last[k] !== ((k % NUM_FEAT) == NUM_FEAT - 1)) errs++;
      end
      return errs;
   endfunction

   task automatic fill_random(input int n);
      wq.delete();
      for (int k = 0; k < n; k++) wq.push_back(DATA_W'($urandom));
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #1;
      rst_n = 1'b0;
      #2;
      checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL reset out_valid: got %b, expected 0", bus.out_valid); else passes++;
      checks++; if (bus.out_data !== '0) $display("[TB] FAIL reset out_data: got %h, expected 0", bus.out_data); else passes++;
      checks++; if (bus.out_index !== '0) $display("[TB] FAIL reset out_index: got %0d, expected 0", bus.out_index); else passes++;
      checks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL reset out_last: got %b, expected 0", bus.out_last); else passes++;
      checks++; if (bus.frame_done !== 1'b0) $display("[TB] FAIL reset frame_done: got %b, expected 0", bus.frame_done); else passes++;
      checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL reset in_ready: got %b, expected 1", bus.in_ready); else passes++;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_single_frame();
      int acc, lastc, lat, errs;
      clear_obs();
      ready_mode = 1;
      wq.delete();
      for (int k = 0; k < NUM_FEAT; k++) wq.push_back(DATA_W'(16'h100 + k));
      send_words(NUM_FEAT + 20, 0, acc, lastc);
      wait_drain();
      errs = stream_errors();
      lat  = (rise_cycles.size() > 0) ? rise_cycles[0] - lastc : -1;
      checks++; if (obs_data.size() !== NUM_FEAT) $display("[TB] FAIL single word count: got %0d, expected %0d", obs_data.size(), NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL single stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (lat !== 2) $display("[TB] FAIL single latency: got %0d, expected 2", lat); else passes++;
      checks++; if (valid_cycles !== NUM_FEAT) $display("[TB] FAIL single valid cycles: got %0d, expected %0d", valid_cycles, NUM_FEAT); else passes++;
      checks++; if (done_count !== 1) $display("[TB] FAIL single frame_done: got %0d, expected 1", done_count); else passes++;
      checks++; if (last_err !== 0) $display("[TB] FAIL single out_last: got %0d errors, expected 0", last_err); else passes++;
   endtask

   task automatic test_backpressure();
      int acc, lastc, errs;
      clear_obs();
      ready_mode = 2;
      wq.delete();
      for (int k = 0; k < NUM_FEAT; k++) wq.push_back(DATA_W'(16'h100 + k));
      send_words(NUM_FEAT + 20, 0, acc, lastc);
      wait_drain();
      errs = stream_errors();
      checks++; if (obs_data.size() !== NUM_FEAT) $display("[TB] FAIL toggle word count: got %0d, expected %0d", obs_data.size(), NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL toggle stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (stab_err !== 0) $display("[TB] FAIL toggle hold: got %0d unstable cycles, expected 0", stab_err); else passes++;
      checks++; if (valid_cycles < 2*NUM_FEAT - 1 || valid_cycles > 2*NUM_FEAT) $display("[TB] FAIL toggle valid cycles: got %0d, expected %0d or %0d", valid_cycles, 2*NUM_FEAT - 1, 2*NUM_FEAT); else passes++;
      checks++; if (done_count !== 1) $display("[TB] FAIL toggle frame_done: got %0d, expected 1", done_count); else passes++;
   endtask

   task automatic test_random_backpressure();
      int acc, lastc, errs;
      clear_obs();
      ready_mode = 3;
      fill_random(2 * NUM_FEAT);
      send_words(4000, 30, acc, lastc);
      wait_drain();
      errs = stream_errors();
      checks++; if (obs_data.size() !== 2*NUM_FEAT) $display("[TB] FAIL random word count: got %0d, expected %0d", obs_data.size(), 2*NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL random stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (stab_err !== 0) $display("[TB] FAIL random hold: got %0d unstable cycles, expected 0", stab_err); else passes++;
      checks++; if (done_count !== 2) $display("[TB] FAIL random frame_done: got %0d, expected 2", done_count); else passes++;
   endtask

   task automatic test_back_to_back();
      int acc, lastc, errs, gap;
      clear_obs();
      ready_mode = 1;
      fill_random(2 * NUM_FEAT);
      send_words(800, 0, acc, lastc);
      wait_drain();
      errs = stream_errors();
      gap  = (rise_cycles.size() > 1 && last_cycles.size() > 0) ? rise_cycles[1] - last_cycles[0] : -1;
      checks++; if (obs_data.size() !== 2*NUM_FEAT) $display("[TB] FAIL b2b word count: got %0d, expected %0d", obs_data.size(), 2*NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL b2b stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (done_count !== 2) $display("[TB] FAIL b2b frame_done: got %0d, expected 2", done_count); else passes++;
`ifdef FC_TX_PINGPONG_EN
      checks++; if (stall_cycles !== 0) $display("[TB] FAIL b2b stall: got %0d, expected 0", stall_cycles); else passes++;
      checks++; if (gap !== 2) $display("[TB] FAIL b2b frame gap: got %0d, expected 2", gap); else passes++;
`else
      checks++; if (stall_cycles < NUM_FEAT + 1) $display("[TB] FAIL b2b stall: got %0d, expected at least %0d", stall_cycles, NUM_FEAT + 1); else passes++;
      checks++; if (gap < NUM_FEAT) $display("[TB] FAIL b2b frame gap: got %0d, expected at least %0d", gap, NUM_FEAT); else passes++;
`endif
   endtask

   task automatic test_full_stall();
      int acc, lastc, errs;
      clear_obs();
      ready_mode = 0;
      fill_random(3 * NUM_FEAT);
      send_words(3*NUM_FEAT + 60, 0, acc, lastc);
      @(negedge clk);
      checks++; if (acc !== NUM_BANKS*NUM_FEAT) $display("[TB] FAIL stall accepted: got %0d, expected %0d", acc, NUM_BANKS*NUM_FEAT); else passes++;
      checks++; if (bus.in_ready !== 1'b0) $display("[TB] FAIL stall in_ready: got %b, expected 0", bus.in_ready); else passes++;
      checks++; if (bus.out_valid !== 1'b1) $display("[TB] FAIL stall out_valid: got %b, expected 1", bus.out_valid); else passes++;
      checks++; if (bus.out_index !== '0) $display("[TB] FAIL stall out_index: got %0d, expected 0", bus.out_index); else passes++;
      checks++; if (bus.out_data !== wq[0]) $display("[TB] FAIL stall out_data: got %h, expected %h", bus.out_data, wq[0]); else passes++;
      @(posedge clk);
      #1;
      ready_mode = 1;
      wait_drain();
      errs = stream_errors();
      checks++; if (obs_data.size() !== NUM_BANKS*NUM_FEAT) $display("[TB] FAIL stall word count: got %0d, expected %0d", obs_data.size(), NUM_BANKS*NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL stall stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (done_count !== NUM_BANKS) $display("[TB] FAIL stall frame_done: got %0d, expected %0d", done_count, NUM_BANKS); else passes++;
   endtask

   task automatic test_reset_mid_frame();
      int acc, lastc, errs, n;
      logic reached;
      clear_obs();
      ready_mode = 0;
      fill_random(NUM_FEAT);
      send_words(NUM_FEAT + 20, 0, acc, lastc);
      ready_mode = 1;
      n = 0;
      reached = 1'b0;
      while (!reached && n < 500) begin
         @(negedge clk);
         reached = bus.out_valid && (bus.out_index == IDX_W'(57));
         n++;
      end
      checks++; if (reached !== 1'b1) $display("[TB] FAIL midreset reach index 57: got %b, expected 1", reached); else passes++;
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (bus.out_valid !== 1'b0) $display("[TB] FAIL midreset out_valid: got %b, expected 0", bus.out_valid); else passes++;
      checks++; if (bus.out_data !== '0) $display("[TB] FAIL midreset out_data: got %h, expected 0", bus.out_data); else passes++;
      checks++; if (bus.out_index !== '0) $display("[TB] FAIL midreset out_index: got %0d, expected 0", bus.out_index); else passes++;
      checks++; if (bus.out_last !== 1'b0) $display("[TB] FAIL midreset out_last: got %b, expected 0", bus.out_last); else passes++;
      checks++; if (bus.frame_done !== 1'b0) $display("[TB] FAIL midreset frame_done: got %b, expected 0", bus.frame_done); else passes++;
      checks++; if (bus.in_ready !== 1'b1) $display("[TB] FAIL midreset in_ready: got %b, expected 1", bus.in_ready); else passes++;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_obs();
      repeat (4) begin
         @(posedge clk);
         #1;
      end
      checks++; if (valid_cycles !== 0) $display("[TB] FAIL midreset stale frame: got %0d valid cycles, expected 0", valid_cycles); else passes++;
      fill_random(NUM_FEAT);
      send_words(NUM_FEAT + 20, 0, acc, lastc);
      wait_drain();
      errs = stream_errors();
      checks++; if (obs_data.size() !== NUM_FEAT) $display("[TB] FAIL midreset word count: got %0d, expected %0d", obs_data.size(), NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL midreset stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (done_count !== 1) $display("[TB] FAIL midreset frame_done: got %0d, expected 1", done_count); else passes++;
   endtask

   task automatic test_extremes();
      int acc, lastc, errs;
      clear_obs();
      ready_mode = 3;
      wq.delete();
      for (int k = 0; k < NUM_FEAT; k++) wq.push_back((k % 2 == 0) ? 16'h8000 : 16'h7FFF);
      send_words(NUM_FEAT + 20, 0, acc, lastc);
      wait_drain();
      errs = stream_errors();
      checks++; if (obs_data.size() !== NUM_FEAT) $display("[TB] FAIL extremes word count: got %0d, expected %0d", obs_data.size(), NUM_FEAT); else passes++;
      checks++; if (errs !== 0) $display("[TB] FAIL extremes stream: got %0d errors, expected 0", errs); else passes++;
      checks++; if (stab_err !== 0) $display("[TB] FAIL extremes hold: got %0d unstable cycles, expected 0", stab_err); else passes++;
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      clear_obs();
      test_reset();
      test_single_frame();
      test_backpressure();
      test_random_backpressure();
      test_back_to_back();
      test_full_stall();
      test_reset_mid_frame();
      test_extremes();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
